// File: rtl/exp_1_alarm_ctrl_pkg.sv
// Shared types and default constants for the exp_1 alarm controller.
// State encoding is fixed so state_o can be decoded directly in debug views.
package exp_1_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL     = 2'd1,
        ST_ALARM    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    localparam int unsigned DEF_QUAL_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 8;
    localparam int unsigned DEF_CNT_W       = 8;

    // Width of the qualification and hold counters (covers 1..255 cycles).
    localparam int unsigned CYC_CNT_W       = 8;

endpackage

// File: rtl/exp_1_alarm_ctrl_sync2.sv
// Generic two-flop synchroniser, asynchronous active-high reset to 0.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exp_1_alarm_ctrl.sv
// Alarm controller for the exp_1 detector: synchronise, qualify, latch, cooldown, count.
// Optional macro ALARM_AUTOCLR_EN: in ALARM, HOLD_CYCLES consecutive low samples clear the alarm.
module exp_1_alarm_ctrl
    import exp_1_alarm_pkg::*;
#(
    parameter int unsigned QUAL_CYCLES = DEF_QUAL_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             func_in,
    input  logic             ack,
    input  logic             cnt_clr,
    output logic             alarm,
    output logic             alarm_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic [1:0]       state_o
);

    localparam logic [CYC_CNT_W-1:0] QUAL_LAST = CYC_CNT_W'(QUAL_CYCLES - 1);
    localparam logic [CYC_CNT_W-1:0] HOLD_LAST = CYC_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CYC_CNT_W-1:0] CYC_ONE   = CYC_CNT_W'(1);

    logic func_s;

    state_e               state_q, state_d;
    logic [CYC_CNT_W-1:0] qual_cnt_q, qual_cnt_d;
    logic [CYC_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]     event_count_q, event_count_d;
    logic                 alarm_q, alarm_pulse_q;
    logic                 alarm_entry;

    sync2 #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (func_in),
        .q_o (func_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            qual_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            event_count_q <= '0;
            alarm_q       <= 1'b0;
            alarm_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            qual_cnt_q    <= qual_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            event_count_q <= event_count_d;
            alarm_q       <= (state_d == ST_ALARM);
            alarm_pulse_q <= alarm_entry;
        end
    end

    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                qual_cnt_d = '0;
                hold_cnt_d = '0;
                if (func_s) begin
                    qual_cnt_d = CYC_ONE;
                    state_d    = (QUAL_CYCLES == 1) ? ST_ALARM : ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (!func_s) begin
                    state_d    = ST_IDLE;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q == QUAL_LAST) begin
                    state_d    = ST_ALARM;
                    qual_cnt_d = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + CYC_ONE;
                end
            end
            ST_ALARM: begin
                // ack wins over auto-clear; hold_cnt is shared with COOLDOWN.
                if (ack) begin
                    state_d    = ST_COOLDOWN;
                    hold_cnt_d = '0;
                end
`ifdef ALARM_AUTOCLR_EN
                else if (func_s) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CYC_ONE;
                end
`else
                else begin
                    hold_cnt_d = '0;
                end
`endif
            end
            ST_COOLDOWN: begin
                if (func_s) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CYC_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                qual_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign alarm_entry = (state_d == ST_ALARM) && (state_q != ST_ALARM);

    // A clear coincident with an entry keeps that entry as the first new event.
    always_comb begin
        event_count_d = event_count_q;
        if (cnt_clr) begin
            event_count_d = alarm_entry ? CNT_W'(1) : '0;
        end else if (alarm_entry && (event_count_q != '1)) begin
            event_count_d = event_count_q + CNT_W'(1);
        end
    end

    assign alarm       = alarm_q;
    assign alarm_pulse = alarm_pulse_q;
    assign event_count = event_count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_exp_1_alarm_ctrl.sv
// Scoreboard bench for exp_1_alarm_ctrl (CNT_W=2 to reach saturation quickly).
module tb_exp_1_alarm_ctrl;

    localparam int unsigned TB_CNT_W = 2;
    localparam int          CNT_MAX  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                func_in;
    logic                ack;
    logic                cnt_clr;
    logic                alarm;
    logic                alarm_pulse;
    logic [TB_CNT_W-1:0] event_count;
    logic [1:0]          state_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    exp_1_alarm_ctrl #(
        .QUAL_CYCLES (4),
        .HOLD_CYCLES (8),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .func_in     (func_in),
        .ack         (ack),
        .cnt_clr     (cnt_clr),
        .alarm       (alarm),
        .alarm_pulse (alarm_pulse),
        .event_count (event_count),
        .state_o     (state_o)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic expect_entry(input int new_cnt);
        exp_cnt = new_cnt;
        exp_q.push_back(new_cnt);
    endtask

    // Monitor: every alarm pulse must match the next queued expected count.
    always @(negedge clk) begin
        if (!rst && alarm_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse with count %0d expected no pulse", event_count);
            end else begin
                chk("pulse_event_count", 32'(event_count), exp_q.pop_front());
            end
        end
    end

    task automatic do_alarm(input int ack_delay);
        func_in = 1'b1;
        expect_entry(sat_inc(exp_cnt));
        tick(6);
        chk("da_alarm", 32'(alarm), 1);
        chk("da_pulse", 32'(alarm_pulse), 1);
        if (ack_delay > 0) tick(ack_delay);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("da_cooldown", 32'(state_o), 3);
        func_in = 1'b0;
        tick(11);
        chk("da_idle", 32'(state_o), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; func_in = 1'b0; ack = 1'b0; cnt_clr = 1'b0;
        tick(3);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_pulse", 32'(alarm_pulse), 0);
        chk("rst_count", 32'(event_count), 0);
        chk("rst_state", 32'(state_o), 0);
        rst = 1'b0;

        // Qualify: high before edge 1, alarm after edge 6.
        func_in = 1'b1;
        expect_entry(1);
        tick(5);
        chk("q_alarm_e5", 32'(alarm), 0);
        chk("q_state_e5", 32'(state_o), 1);
        tick(1);
        chk("q_alarm_e6", 32'(alarm), 1);
        chk("q_pulse_e6", 32'(alarm_pulse), 1);
        chk("q_state_e6", 32'(state_o), 2);
        chk("q_count_e6", 32'(event_count), 1);
        tick(1);
        chk("q_pulse_e7", 32'(alarm_pulse), 0);
        chk("q_alarm_e7", 32'(alarm), 1);
        tick(3);
        chk("q_alarm_held", 32'(alarm), 1);

        // Ack and cooldown with restart of the hold count.
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_state", 32'(state_o), 3);
        chk("ack_alarm", 32'(alarm), 0);
        tick(3);
        chk("cd_func_high", 32'(state_o), 3);
        func_in = 1'b0;
        tick(7);
        func_in = 1'b1;
        tick(3);
        chk("cd_restart", 32'(state_o), 3);
        tick(2);
        func_in = 1'b0;
        tick(9);
        chk("cd_7_low", 32'(state_o), 3);
        tick(1);
        chk("cd_exit", 32'(state_o), 0);

        // Glitch of 3 synchronised samples never alarms.
        func_in = 1'b1;
        tick(3);
        func_in = 1'b0;
        chk("gl_qual", 32'(state_o), 1);
        tick(2);
        chk("gl_qual_late", 32'(state_o), 1);
        tick(1);
        chk("gl_idle", 32'(state_o), 0);
        tick(6);
        chk("gl_alarm", 32'(alarm), 0);
        chk("gl_count", 32'(event_count), 1);

        // Ack in the pulse cycle, then drive the counter into saturation.
        do_alarm(0);
        do_alarm(2);
        do_alarm(2);
        do_alarm(2);
        chk("sat_count", 32'(event_count), CNT_MAX);

        // Clear coincident with an alarm entry keeps that event.
        func_in = 1'b1;
        expect_entry(1);
        tick(5);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_coinc_count", 32'(event_count), 1);
        chk("clr_coinc_alarm", 32'(alarm), 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        func_in = 1'b0;
        tick(11);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_plain", 32'(event_count), 0);
        exp_cnt = 0;

        // Asynchronous reset mid-ALARM, then re-alarm 6 edges after release.
        func_in = 1'b1;
        expect_entry(1);
        tick(8);
        chk("ra_alarm", 32'(alarm), 1);
        rst = 1'b1;
        #1;
        chk("ra_async_alarm", 32'(alarm), 0);
        chk("ra_async_count", 32'(event_count), 0);
        chk("ra_async_state", 32'(state_o), 0);
        tick(2);
        rst = 1'b0;
        expect_entry(1);
        tick(5);
        chk("ra_e5", 32'(alarm), 0);
        tick(1);
        chk("ra_e6_alarm", 32'(alarm), 1);
        chk("ra_e6_pulse", 32'(alarm_pulse), 1);

        // Alarm held without ack while the input falls low.
        func_in = 1'b0;
`ifdef ALARM_AUTOCLR_EN
        tick(9);
        chk("ac_still_alarm", 32'(alarm), 1);
        chk("ac_still_state", 32'(state_o), 2);
        tick(1);
        chk("ac_cleared", 32'(alarm), 0);
        chk("ac_idle", 32'(state_o), 0);
        chk("ac_count", 32'(event_count), 1);
`else
        tick(20);
        chk("nac_alarm", 32'(alarm), 1);
        chk("nac_state", 32'(state_o), 2);
        chk("nac_count", 32'(event_count), 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("nac_ack", 32'(alarm), 0);
`endif
        tick(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
